// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage plus the IF/ID pipeline register.
// Owns the PC and keeps at most one instruction-memory request in flight.
// Stalls, EX-stage redirects and memory latency all appear to Decode as bubbles.
// Optional build macro FETCH_PERF_CNT_EN adds saturating stall/redirect counters.
module fetch_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            F_stall_pc,
    input  logic            F_stall_fetch_reg,
    input  logic            E_redirect_en,
    input  logic [XLEN-1:0] E_redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic [31:0]     D_instr,
    output logic [XLEN-1:0] D_pc,
    output logic [XLEN-1:0] D_pc_plus4,
    output logic            D_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_stall_cycles,
    output logic [31:0]     perf_redirects
`endif
);

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT,
        ST_HOLD
    } fetchState_t;

    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
    localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

    fetchState_t     r_state;
    fetchState_t     w_stateNext;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pcNext;
    logic [XLEN-1:0] w_pcPlus4;
    logic [XLEN-1:0] w_redirTarget;
    logic            r_drop;
    logic            w_dropNext;
    logic            r_live;
    logic [31:0]     r_holdInstr;
    logic [31:0]     w_holdInstrNext;
    logic            w_stall;
    logic            w_handshake;
    logic            w_deliver;
    logic [31:0]     w_deliverInstr;

    logic [31:0]     r_dInstr;
    logic [31:0]     w_dInstrNext;
    logic [XLEN-1:0] r_dPc;
    logic [XLEN-1:0] w_dPcNext;
    logic [XLEN-1:0] r_dPcPlus4;
    logic [XLEN-1:0] w_dPcPlus4Next;
    logic            r_dValid;
    logic            w_dValidNext;

    assign w_stall        = F_stall_pc | F_stall_fetch_reg;
    assign imem_req_valid = r_live && (r_state == ST_REQ);
    assign imem_req_addr  = r_pc & WORD_MASK;
    assign w_handshake    = imem_req_valid & imem_req_ready;
    assign w_pcPlus4      = r_pc + PC_STEP;
    assign w_redirTarget  = E_redirect_pc & WORD_MASK;

    assign D_instr    = r_dInstr;
    assign D_pc       = r_dPc;
    assign D_pc_plus4 = r_dPcPlus4;
    assign D_valid    = r_dValid;

    // Gate the first request by one cycle so valid only rises after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    // Fetch FSM next-state: a redirect overrides everything, then stall, then normal flow.
    always_comb begin
        w_stateNext     = r_state;
        w_pcNext        = r_pc;
        w_dropNext      = r_drop;
        w_holdInstrNext = r_holdInstr;
        w_deliver       = 1'b0;
        w_deliverInstr  = r_holdInstr;
        if (E_redirect_en) begin
            w_pcNext        = w_redirTarget;
            w_holdInstrNext = NOP_INSTR;
            w_dropNext      = 1'b0;
            w_stateNext     = ST_REQ;
            case (r_state)
                ST_REQ: begin
                    if (w_handshake) begin
                        w_dropNext  = 1'b1;
                        w_stateNext = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!imem_rsp_valid) begin
                        w_dropNext  = 1'b1;
                        w_stateNext = ST_WAIT;
                    end
                end
                default: begin
                end
            endcase
        end else begin
            case (r_state)
                ST_REQ: begin
                    if (w_handshake) begin
                        w_stateNext = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (r_drop) begin
                            w_dropNext  = 1'b0;
                            w_stateNext = ST_REQ;
                        end else if (!w_stall) begin
                            w_deliver      = 1'b1;
                            w_deliverInstr = imem_rsp_data;
                            w_pcNext       = w_pcPlus4;
                            w_stateNext    = ST_REQ;
                        end else begin
                            w_holdInstrNext = imem_rsp_data;
                            w_stateNext     = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!w_stall) begin
                        w_deliver      = 1'b1;
                        w_deliverInstr = r_holdInstr;
                        w_pcNext       = w_pcPlus4;
                        w_stateNext    = ST_REQ;
                    end
                end
                default: begin
                    w_stateNext = ST_REQ;
                end
            endcase
        end
    end

    // Fetch FSM, PC, stale-response flag and hold buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_REQ;
            r_pc        <= RESET_PC;
            r_drop      <= 1'b0;
            r_holdInstr <= NOP_INSTR;
        end else begin
            r_state     <= w_stateNext;
            r_pc        <= w_pcNext;
            r_drop      <= w_dropNext;
            r_holdInstr <= w_holdInstrNext;
        end
    end

    // IF/ID next value: redirect or idle cycle gives a bubble, stall freezes, delivery loads.
    always_comb begin
        w_dValidNext   = r_dValid;
        w_dInstrNext   = r_dInstr;
        w_dPcNext      = r_dPc;
        w_dPcPlus4Next = r_dPcPlus4;
        if (E_redirect_en || (!w_stall && !w_deliver)) begin
            w_dValidNext = 1'b0;
            w_dInstrNext = NOP_INSTR;
        end else if (w_deliver) begin
            w_dValidNext   = 1'b1;
            w_dInstrNext   = w_deliverInstr;
            w_dPcNext      = r_pc;
            w_dPcPlus4Next = w_pcPlus4;
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dValid   <= 1'b0;
            r_dInstr   <= NOP_INSTR;
            r_dPc      <= '0;
            r_dPcPlus4 <= PC_STEP;
        end else begin
            r_dValid   <= w_dValidNext;
            r_dInstr   <= w_dInstrNext;
            r_dPc      <= w_dPcNext;
            r_dPcPlus4 <= w_dPcPlus4Next;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perfStall;
    logic [31:0] r_perfRedir;

    // Saturating counts of stalled cycles and redirect cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perfStall <= '0;
            r_perfRedir <= '0;
        end else begin
            if (w_stall && (r_perfStall != 32'hFFFF_FFFF)) begin
                r_perfStall <= r_perfStall + 32'd1;
            end
            if (E_redirect_en && (r_perfRedir != 32'hFFFF_FFFF)) begin
                r_perfRedir <= r_perfRedir + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = r_perfStall;
    assign perf_redirects    = r_perfRedir;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: drives fetch_stage with an in-bench instruction memory and
// checks every cycle against a transaction-level model of the fetch stream.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        F_stall_pc;
    logic        F_stall_fetch_reg;
    logic        E_redirect_en;
    logic [31:0] E_redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] D_instr;
    logic [31:0] D_pc;
    logic [31:0] D_pc_plus4;
    logic        D_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_redirects;
`endif

    always #5 clk = ~clk;

    fetch_stage #(
        .XLEN(32),
        .RESET_PC(32'h0000_0000),
        .NOP_INSTR(NOP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .F_stall_pc(F_stall_pc),
        .F_stall_fetch_reg(F_stall_fetch_reg),
        .E_redirect_en(E_redirect_en),
        .E_redirect_pc(E_redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .D_instr(D_instr),
        .D_pc(D_pc),
        .D_pc_plus4(D_pc_plus4),
        .D_valid(D_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cycles(perf_stall_cycles),
        .perf_redirects(perf_redirects)
`endif
    );

    // Outstanding memory transactions; stale marks ones orphaned by a redirect.
    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } memReq_t;

    memReq_t q[$];

    int total = 0;
    int bad   = 0;

    // Model of the fetch stream: next PC to deliver, a fetched-but-undelivered
    // instruction, and the expected IF/ID contents after the coming edge.
    int          cyc;
    int          latCfg;
    logic [31:0] mPc;
    logic [31:0] mData;
    bit          mAvail;
    bit          mLive;
    bit          eValid;
    logic [31:0] eInstr;
    logic [31:0] ePc;
    int          pStall;
    int          pRedir;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_0000;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic resetModel();
        q.delete();
        cyc    = 0;
        mPc    = 32'h0;
        mData  = NOP;
        mAvail = 1'b0;
        mLive  = 1'b0;
        eValid = 1'b0;
        eInstr = NOP;
        ePc    = 32'h0;
        pStall = 0;
        pRedir = 0;
    endtask

    task automatic modelStep(input bit stallNow, input bit redir, input logic [31:0] target,
                             input bit hand, input logic [31:0] handAddr, input bit rspNow);
        bit      gotRsp;
        memReq_t r;
        gotRsp = 1'b0;
        cyc++;
        if (rspNow && q.size() > 0) begin
            if (!q[0].stale) gotRsp = 1'b1;
            q.delete(0);
        end
        if (redir) begin
            foreach (q[i]) q[i].stale = 1'b1;
            mPc    = target & 32'hFFFF_FFFC;
            mAvail = 1'b0;
            eValid = 1'b0;
            eInstr = NOP;
        end else begin
            if (gotRsp) begin
                mAvail = 1'b1;
                mData  = memf(mPc);
            end
            if (!stallNow) begin
                if (mAvail) begin
                    eValid = 1'b1;
                    eInstr = mData;
                    ePc    = mPc;
                    mPc    = mPc + 32'd4;
                    mAvail = 1'b0;
                end else begin
                    eValid = 1'b0;
                    eInstr = NOP;
                end
            end
        end
        if (hand) begin
            r.addr  = handAddr;
            r.due   = cyc + ((latCfg == 0) ? int'($urandom_range(1, 3)) : latCfg);
            r.stale = redir;
            q.push_back(r);
        end
        if (stallNow) pStall++;
        if (redir) pRedir++;
        mLive = 1'b1;
    endtask

    // Drive one cycle of inputs (including the memory response) and advance the model.
    task automatic applyStimulus(input bit sPc, input bit sReg, input bit redir,
                                 input logic [31:0] target, input bit ready);
        bit rspNow;
        bit hand;
        F_stall_pc        = sPc;
        F_stall_fetch_reg = sReg;
        E_redirect_en     = redir;
        E_redirect_pc     = target;
        imem_req_ready    = ready;
        rspNow            = (q.size() > 0) && (q[0].due <= cyc + 1);
        imem_rsp_valid    = rspNow;
        imem_rsp_data     = rspNow ? memf(q[0].addr) : 32'hDEAD_BEEF;
        hand              = (imem_req_valid === 1'b1) && ready;
        modelStep(sPc | sReg, redir, target, hand, imem_req_addr, rspNow);
        @(negedge clk);
    endtask

    task automatic applyReset(input int cycles);
        #2;
        rst_n             = 1'b0;
        F_stall_pc        = 1'b0;
        F_stall_fetch_reg = 1'b0;
        E_redirect_en     = 1'b0;
        E_redirect_pc     = 32'h0;
        imem_rsp_valid    = 1'b0;
        imem_rsp_data     = 32'h0;
        resetModel();
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic checkOutput();
        bit expReqValid;
        expReqValid = mLive && (q.size() == 0) && !mAvail;
        checkValue("req_valid", {31'h0, imem_req_valid}, {31'h0, expReqValid});
        if (expReqValid) checkValue("req_addr", imem_req_addr, mPc);
        checkValue("D_valid", {31'h0, D_valid}, {31'h0, eValid});
        checkValue("D_instr", D_instr, eInstr);
        if (eValid) begin
            checkValue("D_pc", D_pc, ePc);
            checkValue("D_pc_plus4", D_pc_plus4, ePc + 32'd4);
        end
`ifdef FETCH_PERF_CNT_EN
        checkValue("perf_stall", perf_stall_cycles, 32'(pStall));
        checkValue("perf_redir", perf_redirects, 32'(pRedir));
`endif
    endtask

    // Every-cycle comparison against the model, just after the active edge.
    always begin
        @(posedge clk);
        #2;
        checkOutput();
    end

    initial begin
        rst_n             = 1'b0;
        F_stall_pc        = 1'b0;
        F_stall_fetch_reg = 1'b0;
        E_redirect_en     = 1'b0;
        E_redirect_pc     = 32'h0;
        imem_req_ready    = 1'b1;
        imem_rsp_valid    = 1'b0;
        imem_rsp_data     = 32'h0;
        latCfg            = 1;
        resetModel();

        repeat (3) @(negedge clk);
        checkValue("rst_D_valid", {31'h0, D_valid}, 32'h0);
        checkValue("rst_D_instr", D_instr, 32'h0000_0013);
        checkValue("rst_D_pc", D_pc, 32'h0);
        checkValue("rst_D_pc_plus4", D_pc_plus4, 32'h4);
        checkValue("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);

        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 32'h0, 1);
        checkValue("e1_req_valid", {31'h0, imem_req_valid}, 32'h1);
        checkValue("e1_req_addr", imem_req_addr, 32'h0);
        repeat (2) applyStimulus(0, 0, 0, 32'h0, 1);
        checkValue("e3_D_valid", {31'h0, D_valid}, 32'h1);
        checkValue("e3_D_pc", D_pc, 32'h0);
        checkValue("e3_D_instr", D_instr, 32'h1357_0000);
        checkValue("e3_req_addr", imem_req_addr, 32'h4);
        repeat (4) applyStimulus(0, 0, 0, 32'h0, 1);
        checkValue("e7_D_pc", D_pc, 32'h8);

        // Two stalled cycles: 12 is fetched into the hold buffer, Decode frozen.
        applyStimulus(1, 0, 0, 32'h0, 1);
        applyStimulus(0, 1, 0, 32'h0, 1);
        checkValue("stall_D_valid", {31'h0, D_valid}, 32'h1);
        checkValue("stall_D_pc", D_pc, 32'h8);
        checkValue("stall_req_valid", {31'h0, imem_req_valid}, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 1);
        checkValue("unstall_D_pc", D_pc, 32'hC);
        checkValue("unstall_req_addr", imem_req_addr, 32'h10);

        // Redirect while waiting on 0x10: response dropped, next request at 0x100.
        latCfg = 2;
        applyStimulus(0, 0, 0, 32'h0, 1);
        applyStimulus(0, 0, 1, 32'h100, 1);
        checkValue("redir_D_valid", {31'h0, D_valid}, 32'h0);
        checkValue("redir_D_instr", D_instr, 32'h0000_0013);
        applyStimulus(0, 0, 0, 32'h0, 1);
        checkValue("redir_req_valid", {31'h0, imem_req_valid}, 32'h1);
        checkValue("redir_req_addr", imem_req_addr, 32'h100);

        // Redirect together with stall while an instruction sits in the hold buffer.
        applyStimulus(0, 0, 0, 32'h0, 1);
        applyStimulus(1, 1, 0, 32'h0, 1);
        applyStimulus(1, 1, 0, 32'h0, 1);
        applyStimulus(1, 1, 1, 32'h203, 1);
        checkValue("rs_D_valid", {31'h0, D_valid}, 32'h0);
        checkValue("rs_req_addr", imem_req_addr, 32'h200);
        latCfg = 1;
        repeat (2) applyStimulus(0, 0, 0, 32'h0, 1);
        checkValue("rs_D_pc", D_pc, 32'h200);

        // Memory not ready for three cycles: address held, single request.
        repeat (3) begin
            applyStimulus(0, 0, 0, 32'h0, 0);
            checkValue("nr_req_addr", imem_req_addr, 32'h204);
            checkValue("nr_D_valid", {31'h0, D_valid}, 32'h0);
        end
        repeat (2) applyStimulus(0, 0, 0, 32'h0, 1);
        checkValue("nr_D_pc", D_pc, 32'h204);

        // Randomized traffic, including wrap-around targets and a mid-flight reset.
        latCfg = 0;
        for (int i = 0; i < 1600; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            if (i == 800) applyReset(2);
            applyStimulus($urandom_range(0, 99) < 10, $urandom_range(0, 99) < 8,
                          $urandom_range(0, 99) < 4, tgt, $urandom_range(0, 99) < 70);
        end

`ifdef FETCH_PERF_CNT_EN
        applyReset(2);
        latCfg = 1;
        repeat (5) applyStimulus(1, 0, 0, 32'h0, 1);
        repeat (2) applyStimulus(0, 0, 1, 32'h40, 1);
        applyStimulus(0, 0, 0, 32'h0, 1);
        checkValue("perf_stall_lit", perf_stall_cycles, 32'd5);
        checkValue("perf_redir_lit", perf_redirects, 32'd2);
`endif

        repeat (4) applyStimulus(0, 0, 0, 32'h0, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
